dmem_bus_master: RTL

// - Initiator side of the data-memory port. Sits between the pipeline MEM stage and a

---
 rtl/dmem_bus_master_pkg.sv | 6 +
 rtl/dmem_bus_master_timeout_ctr.sv | 16 +
 rtl/dmem_bus_master.sv | 94 +++++++++
 3 files changed

// File: rtl/dmem_bus_master_pkg.sv
// dmem_bus_master_pkg: shared FSM state encoding and data-bus constants
package dmem_bus_master_pkg;
  localparam int BUS_W = 32;
  localparam logic [BUS_W-1:0] DATA_BASE_DEF = 32'h0000_2000;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/dmem_bus_master_timeout_ctr.sv
// dmem_bus_master_timeout_ctr: saturating bus-wait counter that flags when the limit is reached
module dmem_bus_master_timeout_ctr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == limit;
  always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
endmodule

// File: rtl/dmem_bus_master.sv
// dmem_bus_master: turns MEM-stage load/store strobes into timed req/ack data-bus transactions
module dmem_bus_master
  import dmem_bus_master_pkg::*;
#(
  parameter logic [BUS_W-1:0] DATA_BASE = DATA_BASE_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [BUS_W-1:0] adr,
  input  logic [BUS_W-1:0] write_data,
  output logic [BUS_W-1:0] read_data,
  output logic             stall,
  output logic             mem_err,
  output logic             bus_req,
  output logic             bus_we,
  output logic [BUS_W-1:0] bus_addr,
  output logic [BUS_W-1:0] bus_wdata,
  input  logic             bus_ack,
  input  logic [BUS_W-1:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_t state_q, state_d;
  logic bus_req_q, bus_req_d, bus_we_q, bus_we_d, mem_err_q, mem_err_d;
  logic [BUS_W-1:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d, read_data_q, read_data_d;
  logic take, busy, expired;
  assign take = state_q == IDLE && (mem_read || mem_write);
  assign busy = state_q == BUSY;
  assign stall = take || busy;
  assign read_data = read_data_q;
  assign mem_err = mem_err_q;
  assign bus_req = bus_req_q;
  assign bus_we = bus_we_q;
  assign bus_addr = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  dmem_bus_master_timeout_ctr #(.W(CW)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(take),
    .en(busy),
    .limit(CW'(TIMEOUT_CYC - 1)),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    bus_req_d = bus_req_q;
    bus_we_d = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    read_data_d = read_data_q;
    mem_err_d = 1'b0;
    if (take) begin
      if (adr[1:0] != 2'b00) begin
        state_d = DONE;
        mem_err_d = 1'b1;
        read_data_d = '0;
      end else begin
        state_d = BUSY;
        bus_req_d = 1'b1;
        bus_we_d = mem_write;
        bus_addr_d = adr - DATA_BASE;
        bus_wdata_d = write_data;
      end
    end else if (busy && (bus_ack || expired)) begin
      state_d = DONE;
      bus_req_d = 1'b0;
      mem_err_d = !bus_ack;
      read_data_d = (bus_ack && !bus_we_q) ? bus_rdata : '0;
    end else if (state_q != IDLE && !busy) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      bus_req_q <= 1'b0;
      bus_we_q <= 1'b0;
      bus_addr_q <= '0;
      bus_wdata_q <= '0;
      read_data_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_req_q <= bus_req_d;
      bus_we_q <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      read_data_q <= read_data_d;
      mem_err_q <= mem_err_d;
    end
  end
endmodule
